// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t     : controller state encoding (IDLE / RUN / DONE)
//   DZ_FILL_BIT : replicated across the quotient on a divide-by-zero
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic DZ_FILL_BIT = 1'b1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step (purely combinational).
//   r_in  [dw-1:0] : partial remainder before the step
//   q_in  [dw-1:0] : dividend bits not yet consumed / quotient bits so far
//   d_in  [dw-1:0] : divisor
//   r_out [dw-1:0] : partial remainder after shift and trial subtract
//   q_out [dw-1:0] : shifted Q with the new quotient bit in bit 0
module div_step #(
    parameter int dw = 8
) (
    input  logic [dw-1:0] r_in,
    input  logic [dw-1:0] q_in,
    input  logic [dw-1:0] d_in,
    output logic [dw-1:0] r_out,
    output logic [dw-1:0] q_out
);

    logic [dw:0] r_sh;
    logic [dw:0] trial;

    // The partial remainder always stays below the divisor, so it fits in
    // dw bits; only the shifted value and the trial need the extra bit.
    always_comb begin
        r_sh  = {r_in, q_in[dw-1]};
        trial = r_sh - {1'b0, d_in};
        if (trial[dw] == 1'b0) begin
            r_out = trial[dw-1:0];
            q_out = {q_in[dw-2:0], 1'b1};
        end else begin
            r_out = r_sh[dw-1:0];
            q_out = {q_in[dw-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   clk, reset (async, active-high)
//   start, dividend, divisor : request; operands captured on the accepting edge
//   busy        : divide in progress
//   done        : one-cycle pulse, results valid
//   quotient, remainder, div_by_zero : registered results, held until the next
//                                      completion
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one restoring step per edge, dw steps total
// DONE  | results valid, done pulse; returns to IDLE next edge
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int dw = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [dw-1:0] dividend,
    input  logic [dw-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [dw-1:0] quotient,
    output logic [dw-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = $clog2(dw) + 1;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [dw-1:0]  r_q, r_d;
    logic [dw-1:0]  q_q, q_d;
    logic [dw-1:0]  d_q, d_d;
    logic [dw-1:0]  quot_q, quot_d;
    logic [dw-1:0]  rem_q, rem_d;
    logic           dbz_q, dbz_d;

    logic [dw-1:0]  r_step;
    logic [dw-1:0]  q_step;

    div_step #(.dw(dw)) u_step (
        .r_in  (r_q),
        .q_in  (q_q),
        .d_in  (d_q),
        .r_out (r_step),
        .q_out (q_step)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        r_d     = '0;
                        q_d     = dividend;
                        d_d     = divisor;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = RUN;
                    end else begin
                        quot_d  = {dw{DZ_FILL_BIT}};
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q + CW'(1);
                // Last step: publish straight from the step outputs.
                if (cnt_q == CW'(dw - 1)) begin
                    quot_d  = q_step;
                    rem_d   = r_step;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_divider #(.dw(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one accepting edge, then scramble them.
    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
    endtask

    // Called one sample after the accepting edge; returns edges until done.
    task automatic wait_done(output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        while (done !== 1'b1 && lat < 40) begin
            nbusy += int'(busy);
            tick();
            lat++;
        end
    endtask

    task automatic count_done(input int n, output int k);
        k = 0;
        repeat (n) begin
            tick();
            k += int'(done);
        end
    endtask

    int         lat;
    int         nbusy;
    int         k;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] edges [3];

    initial begin
        edges[0] = 8'd0;
        edges[1] = 8'd1;
        edges[2] = 8'd255;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dz", div_by_zero, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // 100 / 7
        issue(8'd100, 8'd7);
        wait_done(lat, nbusy);
        chk("t1_lat", lat, 8);
        chk("t1_busy_cycles", nbusy, 8);
        chk("t1_busy_in_done", busy, 0);
        chk("t1_q", quotient, 14);
        chk("t1_r", remainder, 2);
        chk("t1_dz", div_by_zero, 0);
        tick();
        chk("t1_done_pulse", done, 0);
        tick();
        tick();
        chk("t1_hold_q", quotient, 14);
        chk("t1_hold_r", remainder, 2);

        // 255 / 1 then 5 / 9 with start raised in DONE and held
        issue(8'd255, 8'd1);
        wait_done(lat, nbusy);
        chk("t2a_lat", lat, 8);
        chk("t2a_q", quotient, 255);
        chk("t2a_r", remainder, 0);
        start    = 1'b1;
        dividend = 8'd5;
        divisor  = 8'd9;
        tick();
        chk("t2_idle_busy", busy, 0);
        chk("t2_idle_done", done, 0);
        chk("t2_idle_q", quotient, 255);
        tick();
        start = 1'b0;
        chk("t2b_busy", busy, 1);
        wait_done(lat, nbusy);
        chk("t2b_lat", lat, 8);
        chk("t2b_q", quotient, 0);
        chk("t2b_r", remainder, 5);
        tick();

        // 37 / 0, then 12 / 4 clears the flag
        issue(8'd37, 8'd0);
        wait_done(lat, nbusy);
        chk("t3_lat", lat, 0);
        chk("t3_busy", busy, 0);
        chk("t3_q", quotient, 255);
        chk("t3_r", remainder, 37);
        chk("t3_dz", div_by_zero, 1);
        tick();
        chk("t3_done_pulse", done, 0);
        chk("t3_hold_dz", div_by_zero, 1);
        issue(8'd12, 8'd4);
        wait_done(lat, nbusy);
        chk("t3b_lat", lat, 8);
        chk("t3b_q", quotient, 3);
        chk("t3b_r", remainder, 0);
        chk("t3b_dz", div_by_zero, 0);
        tick();

        // start with new operands during RUN is ignored
        issue(8'd100, 8'd7);
        tick();
        tick();
        tick();
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd3;
        tick();
        start = 1'b0;
        wait_done(lat, nbusy);
        chk("t4_lat", lat, 4);
        chk("t4_q", quotient, 14);
        chk("t4_r", remainder, 2);
        count_done(15, k);
        chk("t4_extra_done", k, 0);

        // async reset mid-RUN
        issue(8'd81, 8'd9);
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_q", quotient, 0);
        chk("t5_rst_r", remainder, 0);
        chk("t5_rst_dz", div_by_zero, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();
        count_done(12, k);
        chk("t5_no_done", k, 0);
        issue(8'd81, 8'd9);
        wait_done(lat, nbusy);
        chk("t5_lat", lat, 8);
        chk("t5_q", quotient, 9);
        chk("t5_r", remainder, 0);
        tick();

        // sweep: edge-value grid first, then random pairs
        for (int i = 0; i < 1000; i++) begin
            if (i < 9) begin
                a = edges[i / 3];
                b = edges[i % 3];
            end else begin
                a = 8'($urandom_range(0, 255));
                case ($urandom_range(0, 9))
                    0:       b = 8'd0;
                    1:       b = 8'd1;
                    2:       b = 8'd255;
                    default: b = 8'($urandom_range(0, 255));
                endcase
            end
            issue(a, b);
            wait_done(lat, nbusy);
            if (b != 8'd0) begin
                chk("sw_lat", lat, 8);
                chk("sw_q", quotient, 32'(a / b));
                chk("sw_r", remainder, 32'(a % b));
                chk("sw_ident", 32'(int'(quotient) * int'(b) + int'(remainder)), 32'(a));
                chk("sw_r_lt_d", (remainder < b), 1);
                chk("sw_dz", div_by_zero, 0);
            end else begin
                chk("sw_z_lat", lat, 0);
                chk("sw_z_q", quotient, 255);
                chk("sw_z_r", remainder, 32'(a));
                chk("sw_z_dz", div_by_zero, 1);
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
